// File: rtl/low_freq_fir.sv
// Low-band FIR stage: one multiply-accumulate per sequencing cycle per channel,
// one saturated 16-bit result per channel when the window ends.
module low_freq_fir #(
  parameter COEFF_FILE = "low_freq_coeff.hex",
  parameter int ACC_W = 42
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sequencing,
  input  logic signed [15:0] lft_in,
  input  logic signed [15:0] rght_in,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               valid
);

  localparam int NCH = 2;
  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -ACC_W'(32768);

  // Q1.15 coefficients; contents come from COEFF_FILE via the memory-init flow.
  logic signed [15:0] coeff_rom [1024];
  logic signed [15:0] coeff_reg;

  logic [9:0]         caddr_reg;
  logic               seq_d1_reg;
  logic               seq_d2_reg;
  logic               seq_d3_reg;
  logic               valid_reg;
  logic               capture;
  logic signed [15:0] sample [NCH];

  assign sample  = '{lft_in, rght_in};
  assign capture = seq_d3_reg & ~seq_d2_reg;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> 15;
    if (shifted > POS_LIM) begin
      return 16'sh7FFF;
    end else if (shifted < NEG_LIM) begin
      return 16'sh8000;
    end
    return acc[30:15];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      caddr_reg  <= '0;
      seq_d1_reg <= 1'b0;
      seq_d2_reg <= 1'b0;
      seq_d3_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      caddr_reg  <= sequencing ? caddr_reg + 10'd1 : 10'd0;
      seq_d1_reg <= sequencing;
      seq_d2_reg <= seq_d1_reg;
      seq_d3_reg <= seq_d2_reg;
      valid_reg  <= capture;
    end
  end

  // Registered read, no reset, so the ROM maps onto block RAM.
  always_ff @(posedge clk) begin
    coeff_reg <= coeff_rom[caddr_reg];
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [31:0]      prod_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [15:0]      result_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_reg   <= '0;
        acc_reg    <= '0;
        result_reg <= '0;
      end else begin
        if (seq_d1_reg) begin
          prod_reg <= 32'(sample[gi]) * 32'(coeff_reg);
        end
        // First window cycle restarts the sum instead of adding to the old one.
        if (seq_d2_reg) begin
          acc_reg <= (seq_d3_reg ? acc_reg : '0) + ACC_W'(prod_reg);
        end
        if (capture) begin
          result_reg <= sat16(acc_reg);
        end
      end
    end
  end

  assign lft_out  = g_ch[0].result_reg;
  assign rght_out = g_ch[1].result_reg;
  assign valid    = valid_reg;

endmodule

// File: tb/tb_low_freq_fir.sv
// Randomised scoreboard bench for low_freq_fir against a plain-arithmetic convolution model.
module tb_low_freq_fir;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sequencing = 1'b0;
  logic signed [15:0] lft_in = '0;
  logic signed [15:0] rght_in = '0;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int txn = 0;
  int rom_m [1024];
  int sl[$];
  int sr[$];

  typedef struct {
    int l;
    int r;
    int c;
  } exp_t;
  exp_t exp_q[$];

  low_freq_fir dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sequencing(sequencing),
    .lft_in    (lft_in),
    .rght_in   (rght_in),
    .lft_out   (lft_out),
    .rght_out  (rght_out),
    .valid     (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  function automatic int sat_ref(input longint a);
    longint s;
    s = a >>> 15;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 1024; i++) dut.coeff_rom[i] = 16'(rom_m[i]);
  endtask

  task automatic set_rom(input int first, input int last, input int val);
    for (int i = 0; i < 1024; i++) rom_m[i] = (i >= first && i <= last) ? val : 0;
    load_rom();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      sequencing = 1'b0;
      lft_in  = 16'($urandom);
      rght_in = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Plays sl/sr as one window; the expected result is a straight convolution sum.
  task automatic burst();
    exp_t   e;
    longint al;
    longint ar;
    int     len;
    len = sl.size();
    al = 0;
    ar = 0;
    for (int k = 0; k < len; k++) begin
      al += longint'(sl[k]) * longint'(rom_m[k % 1024]);
      ar += longint'(sr[k]) * longint'(rom_m[k % 1024]);
    end
    e.l = sat_ref(al);
    e.r = sat_ref(ar);
    e.c = 0;
    for (int k = 0; k <= len; k++) begin
      sequencing = (k < len);
      if (k > 0) begin
        lft_in  = 16'(sl[k-1]);
        rght_in = 16'(sr[k-1]);
      end else begin
        lft_in  = 16'($urandom);
        rght_in = 16'($urandom);
      end
      if (k == len - 1) begin
        e.c = cyc + 4;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    sequencing = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got valid=1 at cycle %0d, required no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d cycle %0d lft_out=%0d rght_out=%0d", txn, cyc, lft_out, rght_out);
          check("valid_cycle", cyc, e.c);
          check("lft_out", int'(lft_out), e.l);
          check("rght_out", int'(rght_out), e.r);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].c) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_valid: got no pulse by cycle %0d, required one at cycle %0d", cyc, e.c);
      end
    end
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    set_rom(0, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_lft_out", int'(lft_out), 0);
    check("reset_rght_out", int'(rght_out), 0);
    check("reset_valid", int'(valid), 0);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    idle(2);

    // Impulse response
    set_rom(0, 0, 32767);
    sl.delete(); sr.delete();
    for (int k = 0; k < 1021; k++) begin
      sl.push_back(k == 0 ? 16384 : 0);
      sr.push_back(rnd16());
    end
    burst();
    idle(6);

    // Flat sum
    set_rom(0, 1020, 32);
    sl.delete(); sr.delete();
    for (int k = 0; k < 1021; k++) begin
      sl.push_back(256);
      sr.push_back(256);
    end
    burst();
    idle(6);

    // Saturation, both polarities on both channels
    set_rom(0, 1023, 32767);
    for (int pass = 0; pass < 2; pass++) begin
      sl.delete(); sr.delete();
      for (int k = 0; k < 1021; k++) begin
        sl.push_back(pass == 0 ? 32767 : -32768);
        sr.push_back(pass == 0 ? -32768 : 32767);
      end
      burst();
      idle(6);
    end

    // Back-to-back windows separated by one idle cycle
    set_rom(0, 2, 32767);
    sl = '{1000, 2000, 3000};
    sr = '{-1000, -2000, -3000};
    burst();
    sl = '{10, 20, 30};
    sr = '{-10, -20, -30};
    burst();
    idle(8);
    wait_drain(10);

    // Reset in the middle of a window, then a window starting on the release cycle
    set_rom(0, 0, 32767);
    for (int k = 0; k < 500; k++) begin
      sequencing = 1'b1;
      lft_in  = (k == 1) ? 16'sh4000 : 16'sh0000;
      rght_in = 16'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    sequencing = 1'b0;
    #1;
    check("midreset_lft_out", int'(lft_out), 0);
    check("midreset_rght_out", int'(rght_out), 0);
    check("midreset_valid", int'(valid), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sl.delete(); sr.delete();
    for (int k = 0; k < 1021; k++) begin
      sl.push_back(k == 0 ? 16384 : 0);
      sr.push_back(k == 0 ? -16384 : 0);
    end
    burst();
    idle(8);

    // Address wrap past 1024 taps
    sl.delete(); sr.delete();
    for (int k = 0; k < 1030; k++) begin
      sl.push_back((k == 0 || k == 1024) ? 16384 : 0);
      sr.push_back(rnd16());
    end
    burst();
    idle(6);

    // Random coefficients, lengths, gaps and samples
    for (int i = 0; i < 1024; i++) rom_m[i] = rnd16();
    load_rom();
    for (int b = 0; b < 25; b++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 60));
      sl.delete(); sr.delete();
      for (int k = 0; k < len; k++) begin
        sl.push_back(rnd16());
        sr.push_back(rnd16());
      end
      burst();
      idle(int'($urandom_range(0, 3)));
    end
    idle(8);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
